conv_calc_seq: RTL and testbench

CONV_CALC_SEQ -- requirements
Module: conv_calc_seq

---
 rtl/conv_calc_seq_if.sv | 36 +++
 rtl/conv_calc_seq.sv | 162 ++++++++++++++++
 tb/tb_conv_calc_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_calc_seq_if.sv
// Coefficient-write, window-input and result-output bundle for conv_calc_seq.
// Signals only; no storage or timing of its own.
// Master drives cfg/in_win/out_ready, slave drives ready/valid/results.
interface conv_calc_seq_if #(
    parameter int FILTER_NUM = 64,
    parameter int LANES      = 8,
    parameter int DATA_W     = 32
);
    localparam int G      = FILTER_NUM / LANES;
    localparam int ADDR_W = $clog2(FILTER_NUM * 10);
    localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;

    logic                      cfg_we;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [DATA_W-1:0]         cfg_wdata;
    logic                      cfg_err;
    logic                      in_valid;
    logic                      in_ready;
    logic [9*DATA_W-1:0]       in_win;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;
    logic [GRP_W-1:0]          out_grp;
    logic                      out_last;
    logic                      busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_win, out_ready,
        input  cfg_err, in_ready, out_valid, out_data, out_grp, out_last, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_win, out_ready,
        output cfg_err, in_ready, out_valid, out_data, out_grp, out_last, busy
    );
endinterface

// File: rtl/conv_calc_seq.sv
// Sequential 3x3 convolution: LANES filters per group, 9 MAC cycles then one result beat per group.
// Latency: first out_valid 10 cycles after window accept; G*10+1 cycles window to window.
// Backpressure: result held stable while out_ready is low; in_ready only while idle.
module conv_calc_seq #(
    parameter int FILTER_NUM = 64,
    parameter int LANES      = 8,
    parameter int DATA_W     = 32,
    parameter int FRAC       = 16,
    parameter int RELU       = 1
) (
    input  logic            clk,
    input  logic            rst,
    conv_calc_seq_if.slave  bus
);
    localparam int G      = FILTER_NUM / LANES;
    localparam int DEPTH  = FILTER_NUM * 10;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;
    localparam int ACC_W  = 2 * DATA_W - FRAC + 4;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    state_t                  state_q, state_d;
    logic [3:0]              tap_q, tap_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    acc_t                    acc_q [LANES];
    acc_t                    acc_d [LANES];
    logic [9*DATA_W-1:0]     win_q, win_d;
    logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    cfg_ok;
    logic [DATA_W-1:0]       coef_mem [DEPTH];

    function automatic logic [ADDR_W-1:0] w_addr(input int f, input int t);
        return ADDR_W'(f * 9 + t);
    endfunction

    function automatic logic [ADDR_W-1:0] b_addr(input int f);
        return ADDR_W'(FILTER_NUM * 9 + f);
    endfunction

    function automatic acc_t sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Full-width signed product, arithmetic shift drops the fraction (rounds toward -inf).
    function automatic acc_t mac_term(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] w);
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] we;
        logic signed [PROD_W-1:0] p;
        xe = {{DATA_W{x[DATA_W-1]}}, x};
        we = {{DATA_W{w[DATA_W-1]}}, w};
        p  = xe * we;
        return ACC_W'(p >>> FRAC);
    endfunction

    // Clamp to the DATA_W signed range, then optionally zero negatives.
    function automatic logic [DATA_W-1:0] sat_relu(input acc_t a);
        logic [DATA_W-1:0]      r;
        logic [ACC_W-DATA_W:0]  hi;
        hi = a[ACC_W-1:DATA_W-1];
        if ((&hi) || !(|hi)) r = a[DATA_W-1:0];
        else if (a[ACC_W-1]) r = {1'b1, {(DATA_W-1){1'b0}}};
        else                 r = {1'b0, {(DATA_W-1){1'b1}}};
        if (RELU != 0 && r[DATA_W-1]) r = '0;
        return r;
    endfunction

    // Coefficient writes land only while idle and in range; anything else is dropped.
    assign cfg_ok = bus.cfg_we && (state_q == IDLE) && (32'(bus.cfg_addr) < DEPTH);

    // Coefficient store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (cfg_ok) coef_mem[bus.cfg_addr] <= bus.cfg_wdata;
    end

    // Next-state: accept window, step one tap per cycle, present a beat per group.
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        grp_d      = grp_q;
        acc_d      = acc_q;
        win_d      = win_q;
        out_data_d = out_data_q;
        cfg_err_d  = bus.cfg_we && !cfg_ok;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    win_d = bus.in_win;
                    tap_d = '0;
                    grp_d = '0;
                    // A bias written in the accept cycle must already be seen here.
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = sext((cfg_ok && bus.cfg_addr == b_addr(l)) ?
                                        bus.cfg_wdata : coef_mem[b_addr(l)]);
                    end
                    state_d = MAC;
                end
            end
            MAC: begin
                for (int l = 0; l < LANES; l++) begin
                    acc_d[l] = acc_q[l] + mac_term(win_q[int'(tap_q)*DATA_W +: DATA_W],
                        coef_mem[w_addr(int'(grp_q) * LANES + l, int'(tap_q))]);
                end
                if (tap_q == 4'd8) begin
                    for (int l = 0; l < LANES; l++) begin
                        out_data_d[l*DATA_W +: DATA_W] = sat_relu(acc_d[l]);
                    end
                    state_d = OUT;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (grp_q == GRP_W'(G - 1)) begin
                        state_d = IDLE;
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                        tap_d = '0;
                        for (int l = 0; l < LANES; l++) begin
                            acc_d[l] = sext(coef_mem[b_addr((int'(grp_q) + 1) * LANES + l)]);
                        end
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any window in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            grp_q      <= '0;
            win_q      <= '0;
            out_data_q <= '0;
            cfg_err_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            grp_q      <= grp_d;
            win_q      <= win_d;
            out_data_q <= out_data_d;
            cfg_err_q  <= cfg_err_d;
            for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_grp   = grp_q;
    assign bus.out_last  = (state_q == OUT) && (grp_q == GRP_W'(G - 1));
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_conv_calc_seq.sv
// Scoreboard bench: two DUTs (RELU=1 and RELU=0) share stimulus; expected beats are
// queued from a plain-arithmetic model when each window is issued, and a monitor pops
// and compares on every accepted output beat.
module tb_conv_calc_seq;
    localparam int FN = 4, LN = 2, DW = 32, FR = 16, G = FN / LN, DEPTH = FN * 10;

    typedef struct {
        logic [LN*DW-1:0] data;
        int               grp;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_calc_seq_if #(.FILTER_NUM(FN), .LANES(LN), .DATA_W(DW)) bus0();
    conv_calc_seq_if #(.FILTER_NUM(FN), .LANES(LN), .DATA_W(DW)) bus1();

    assign bus1.cfg_we    = bus0.cfg_we;
    assign bus1.cfg_addr  = bus0.cfg_addr;
    assign bus1.cfg_wdata = bus0.cfg_wdata;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_win    = bus0.in_win;
    assign bus1.out_ready = bus0.out_ready;

    conv_calc_seq #(.FILTER_NUM(FN), .LANES(LN), .DATA_W(DW), .FRAC(FR), .RELU(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    conv_calc_seq #(.FILTER_NUM(FN), .LANES(LN), .DATA_W(DW), .FRAC(FR), .RELU(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               rdy_mode = 0;
    int               acc_cyc = 0;
    int               last_acc = 0;
    bit               b2b_chk = 1'b0;
    bit               pend_first [2];
    bit               stall_prev [2];
    logic [LN*DW-1:0] stall_dat [2];
    logic [0:0]       stall_grp [2];
    logic [DW-1:0]    wm [DEPTH];
    beat_t            exp_q [2][$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, required DUT event", name);
    endtask

    // Reference: fixed-point dot product on 64-bit integers, then clamp and ReLU.
    function automatic logic [DW-1:0] model_lane(input int f, input logic [DW-1:0] w [9], input bit relu);
        longint acc;
        longint p;
        logic [DW-1:0] r;
        acc = longint'($signed(wm[FN*9+f]));
        for (int t = 0; t < 9; t++) begin
            p = longint'($signed(w[t])) * longint'($signed(wm[f*9+t]));
            acc += p >>> FR;
        end
        if (acc > 64'sd2147483647)       r = 32'h7FFF_FFFF;
        else if (acc < -64'sd2147483648) r = 32'h8000_0000;
        else                             r = acc[DW-1:0];
        if (relu && r[DW-1]) r = '0;
        return r;
    endfunction

    task automatic push_expected(input logic [DW-1:0] w [9]);
        beat_t b;
        for (int g = 0; g < G; g++) begin
            for (int d = 0; d < 2; d++) begin
                b.data = '0;
                for (int l = 0; l < LN; l++) b.data[l*DW +: DW] = model_lane(g*LN + l, w, d == 0);
                b.grp  = g;
                b.last = (g == G - 1);
                exp_q[d].push_back(b);
            end
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic orr, input logic [LN*DW-1:0] od,
                       input logic [0:0] og, input logic ol);
        beat_t b;
        if (ov && stall_prev[d]) begin
            chk($sformatf("stall_data dut%0d", d), 64'(od), 64'(stall_dat[d]));
            chk($sformatf("stall_grp dut%0d", d), 64'(og), 64'(stall_grp[d]));
        end
        if (ov && pend_first[d]) begin
            chk($sformatf("first_latency dut%0d", d), 64'(cyc - acc_cyc), 64'(10));
            pend_first[d] = 1'b0;
        end
        if (ov && orr) begin
            if (exp_q[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat dut%0d: got data %h, required no beat", d, od);
            end else begin
                b = exp_q[d].pop_front();
                chk($sformatf("beat_data dut%0d grp%0d", d, b.grp), 64'(od), 64'(b.data));
                chk($sformatf("beat_grp dut%0d", d), 64'(og), 64'(b.grp));
                chk($sformatf("beat_last dut%0d", d), 64'(ol), 64'(b.last));
            end
        end
        stall_prev[d] = ov && !orr;
        stall_dat[d]  = od;
        stall_grp[d]  = og;
    endtask

    // Monitor: compares beats, stall stability, first-beat latency and accept spacing.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.out_valid, bus0.out_ready, bus0.out_data, bus0.out_grp, bus0.out_last);
            mon(1, bus1.out_valid, bus1.out_ready, bus1.out_data, bus1.out_grp, bus1.out_last);
            if (bus0.in_valid && bus0.in_ready) begin
                if (b2b_chk) chk("window_to_window", 64'(cyc - last_acc), 64'(G*10 + 1));
                last_acc   = cyc;
                acc_cyc    = cyc;
                pend_first = '{1'b1, 1'b1};
            end
        end
    end

    // Result-side ready pattern.
    initial begin
        bus0.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus0.out_ready = 1'b1;
                1:       bus0.out_ready = ($urandom_range(0, 3) != 0);
                default: bus0.out_ready = 1'b0;
            endcase
        end
    end

    task automatic do_reset(input int hold);
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        pend_first = '{1'b0, 1'b0};
        stall_prev = '{1'b0, 1'b0};
        b2b_chk    = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input int d, input logic ov, input logic ir, input logic ce, input logic bsy,
                           input logic ol, input logic [LN*DW-1:0] od, input logic [0:0] og);
        chk($sformatf("rst_out_valid dut%0d", d), 64'(ov), 64'(0));
        chk($sformatf("rst_in_ready dut%0d", d), 64'(ir), 64'(1));
        chk($sformatf("rst_cfg_err dut%0d", d), 64'(ce), 64'(0));
        chk($sformatf("rst_busy dut%0d", d), 64'(bsy), 64'(0));
        chk($sformatf("rst_out_last dut%0d", d), 64'(ol), 64'(0));
        chk($sformatf("rst_out_data dut%0d", d), 64'(od), 64'(0));
        chk($sformatf("rst_out_grp dut%0d", d), 64'(og), 64'(0));
    endtask

    task automatic check_reset_state();
        chk_rst(0, bus0.out_valid, bus0.in_ready, bus0.cfg_err, bus0.busy, bus0.out_last,
                bus0.out_data, bus0.out_grp);
        chk_rst(1, bus1.out_valid, bus1.in_ready, bus1.cfg_err, bus1.busy, bus1.out_last,
                bus1.out_data, bus1.out_grp);
    endtask

    task automatic cfg_write(input int addr, input logic [DW-1:0] data, input bit exp_err, input bit apply);
        bus0.cfg_we    = 1'b1;
        bus0.cfg_addr  = 6'(addr);
        bus0.cfg_wdata = data;
        @(posedge clk);
        #1;
        bus0.cfg_we = 1'b0;
        if (apply) wm[addr] = data;
        chk("cfg_err dut0", 64'(bus0.cfg_err), 64'(exp_err));
        chk("cfg_err dut1", 64'(bus1.cfg_err), 64'(exp_err));
    endtask

    task automatic send_window(input logic [DW-1:0] w [9], input bit do_cfg, input int caddr,
                               input logic [DW-1:0] cdat);
        bit ok;
        if (do_cfg) begin
            bus0.cfg_we    = 1'b1;
            bus0.cfg_addr  = 6'(caddr);
            bus0.cfg_wdata = cdat;
            wm[caddr]      = cdat;
        end
        push_expected(w);
        for (int t = 0; t < 9; t++) bus0.in_win[t*DW +: DW] = w[t];
        bus0.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus0.in_ready) ok = 1'b1;
        end
        if (!ok) fail_bound("window_accept");
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.cfg_we   = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) ok = 1'b1;
        end
        if (!ok) fail_bound("result_drain");
        @(posedge clk);
        #1;
        chk("idle_busy dut0", 64'(bus0.busy), 64'(0));
        chk("idle_busy dut1", 64'(bus1.busy), 64'(0));
        chk("idle_in_ready dut0", 64'(bus0.in_ready), 64'(1));
    endtask

    function automatic logic [DW-1:0] rand_val();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w [9];
        bit ok;
        int nw;
        int a;
        bus0.cfg_we = 1'b0; bus0.cfg_addr = '0; bus0.cfg_wdata = '0;
        bus0.in_valid = 1'b0; bus0.in_win = '0;

        do_reset(3);
        check_reset_state();

        // Unit weights, zero bias, unit window: every lane 9.0.
        for (int i = 0; i < FN*9; i++) cfg_write(i, 32'h0001_0000, 1'b0, 1'b1);
        for (int f = 0; f < FN; f++) cfg_write(FN*9 + f, 32'h0, 1'b0, 1'b1);
        for (int t = 0; t < 9; t++) w[t] = 32'h0001_0000;
        send_window(w, 1'b0, 0, 0);
        wait_drain();

        // Negative bias on filter 0: -11.0 unclamped, 0 with ReLU.
        cfg_write(FN*9, 32'hFFEC_0000, 1'b0, 1'b1);
        send_window(w, 1'b0, 0, 0);
        wait_drain();

        // Hold the first beat for five cycles.
        rdy_mode = 2;
        send_window(w, 1'b0, 0, 0);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus0.out_valid) ok = 1'b1;
        end
        if (!ok) fail_bound("stall_first_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(bus0.in_ready), 64'(0));
            chk("stall_out_valid", 64'(bus0.out_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain();

        // Write during MAC is dropped; rerun must match the unchanged model.
        send_window(w, 1'b0, 0, 0);
        cfg_write(0, 32'h1234_5678, 1'b1, 1'b0);
        wait_drain();
        send_window(w, 1'b0, 0, 0);
        wait_drain();
        cfg_write(DEPTH, 32'h1, 1'b1, 1'b0);
        cfg_write(63, 32'h1, 1'b1, 1'b0);

        // Saturation both ways.
        for (int i = 0; i < FN*9; i++) cfg_write(i, 32'h03E8_0000, 1'b0, 1'b1);
        cfg_write(FN*9, 32'h0, 1'b0, 1'b1);
        for (int t = 0; t < 9; t++) w[t] = 32'h03E8_0000;
        send_window(w, 1'b0, 0, 0);
        wait_drain();
        for (int i = 0; i < FN*9; i++) cfg_write(i, 32'hFC18_0000, 1'b0, 1'b1);
        send_window(w, 1'b0, 0, 0);
        wait_drain();

        // Back-to-back windows with unit weights.
        for (int i = 0; i < FN*9; i++) cfg_write(i, 32'h0001_0000, 1'b0, 1'b1);
        for (int t = 0; t < 9; t++) w[t] = 32'h0001_0000;
        send_window(w, 1'b0, 0, 0);
        b2b_chk = 1'b1;
        send_window(w, 1'b0, 0, 0);
        wait_drain();
        b2b_chk = 1'b0;

        // Reset at tap 4: no beat for the aborted window, coefficients survive.
        send_window(w, 1'b0, 0, 0);
        repeat (4) @(posedge clk);
        #2;
        do_reset(2);
        check_reset_state();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid dut0", 64'(bus0.out_valid), 64'(0));
            chk("abort_no_valid dut1", 64'(bus1.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send_window(w, 1'b0, 0, 0);
        wait_drain();

        // Bias written in the very cycle the window is accepted.
        send_window(w, 1'b1, FN*9, 32'h0005_0000);
        wait_drain();

        // Randomized coefficients, windows and ready pattern.
        for (int i = 0; i < DEPTH; i++) cfg_write(i, rand_val(), 1'b0, 1'b1);
        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            nw = $urandom_range(0, 4);
            if (nw > 0) begin
                wait_drain();
                for (int k = 0; k < nw; k++) begin
                    a = $urandom_range(0, 63);
                    cfg_write(a, rand_val(), a >= DEPTH, a < DEPTH);
                end
            end
            for (int t = 0; t < 9; t++) w[t] = rand_val();
            send_window(w, 1'b0, 0, 0);
        end
        wait_drain();
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
